// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and sizing, used by decode, register file and ALU stages.
// Pure declarations: no logic, no latency, no flow control.
package mips_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/mips_register_file_if.sv
// Register file access bundle: one write port, one paired read request, two operand buses.
// Read data appears one cycle after read_en; no backpressure, the ALU stage always accepts.
interface mips_register_file_if;
    import mips_pkg::*;

    logic     read_en;
    reg_idx_t read_reg1;
    reg_idx_t read_reg2;
    logic     write_en;
    reg_idx_t write_reg;
    word_t    write_data;
    word_t    value1;
    word_t    value2;
    logic     operands_valid;

    modport master (
        output read_en, read_reg1, read_reg2, write_en, write_reg, write_data,
        input  value1, value2, operands_valid
    );

    modport slave (
        input  read_en, read_reg1, read_reg2, write_en, write_reg, write_data,
        output value1, value2, operands_valid
    );
endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: index decode, $zero forcing, optional same-cycle write bypass.
// Latency 1 cycle; value holds when read_en is low; no backpressure.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read_en,
    input  reg_idx_t                 read_reg,
    input  logic                     write_en,
    input  reg_idx_t                 write_reg,
    input  word_t                    write_data,
    input  word_t [NUM_REGS-1:0]     mem,
    output word_t                    value
);

    word_t rd_dat;

`ifdef REGFILE_WRITE_BYPASS_EN
    always_comb begin
        rd_dat = mem[read_reg];
        if (write_en && (write_reg != REG_ZERO) && (write_reg == read_reg))
            rd_dat = write_data;
        if (read_reg == REG_ZERO)
            rd_dat = '0;
    end
`else
    // Read-before-write: a colliding write only becomes visible next cycle.
    logic unused_wr;
    assign unused_wr = ^{write_en, write_reg, write_data};

    always_comb begin
        rd_dat = mem[read_reg];
        if (read_reg == REG_ZERO)
            rd_dat = '0;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            value <= '0;
        else if (read_en)
            value <= rd_dat;
    end

endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS GPR file, two registered read ports, one write port, $zero hardwired (REGFILE_WRITE_BYPASS_EN: write-to-read bypass).
// Latency 1 cycle read_en -> operands_valid; no backpressure, one operand pair per cycle.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic                 clock,
    input  logic                 reset,
    mips_register_file_if.slave  rf
);

    word_t [NUM_REGS-1:0] mem;
    logic                 valid_q;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mem <= '0;
        else if (rf.write_en && (rf.write_reg != REG_ZERO))
            mem[rf.write_reg] <= rf.write_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valid_q <= 1'b0;
        else
            valid_q <= rf.read_en;
    end

    assign rf.operands_valid = valid_q;

    regfile_read_port #(.NUM_REGS(NUM_REGS)) u_port1 (
        .clock      (clock),
        .reset      (reset),
        .read_en    (rf.read_en),
        .read_reg   (rf.read_reg1),
        .write_en   (rf.write_en),
        .write_reg  (rf.write_reg),
        .write_data (rf.write_data),
        .mem        (mem),
        .value      (rf.value1)
    );

    regfile_read_port #(.NUM_REGS(NUM_REGS)) u_port2 (
        .clock      (clock),
        .reset      (reset),
        .read_en    (rf.read_en),
        .read_reg   (rf.read_reg2),
        .write_en   (rf.write_en),
        .write_reg  (rf.write_reg),
        .write_data (rf.write_data),
        .mem        (mem),
        .value      (rf.value2)
    );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: reset, basic read/write, $zero, collision, hold, full sweep.
module tb_mips_register_file;
    import mips_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mips_register_file_if rf();

    mips_register_file dut (
        .clock (clock),
        .reset (reset),
        .rf    (rf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rf.read_en    = 1'b0;
        rf.write_en   = 1'b0;
        rf.read_reg1  = '0;
        rf.read_reg2  = '0;
        rf.write_reg  = '0;
        rf.write_data = '0;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        idle();
        rf.write_en   = 1'b1;
        rf.write_reg  = idx[4:0];
        rf.write_data = d;
        tick();
    endtask

    task automatic rd(input int a, input int b);
        idle();
        rf.read_en   = 1'b1;
        rf.read_reg1 = a[4:0];
        rf.read_reg2 = b[4:0];
        tick();
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        logic [31:0] k;
        k = 32'h01010101;
        return (i == 0) ? 32'h0 : k * i[31:0];
    endfunction

    initial begin
        idle();
        #12;
        chk("reset_value1", rf.value1, 32'h0);
        chk("reset_value2", rf.value2, 32'h0);
        chk("reset_valid",  {31'b0, rf.operands_valid}, 32'h0);
        reset = 1'b0;
        tick();

        // Reset mid-cycle after r5 is written and read back.
        wr(5, 32'hDEADBEEF);
        rd(5, 5);
        chk("pre_reset_r5", rf.value1, 32'hDEADBEEF);
        chk("pre_reset_valid", {31'b0, rf.operands_valid}, 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("async_value1", rf.value1, 32'h0);
        chk("async_value2", rf.value2, 32'h0);
        chk("async_valid",  {31'b0, rf.operands_valid}, 32'h0);
        rf.write_en   = 1'b1;
        rf.write_reg  = 5'd5;
        rf.write_data = 32'hAAAA5555;
        rf.read_en    = 1'b1;
        tick();
        chk("reset_hold_valid", {31'b0, rf.operands_valid}, 32'h0);
        chk("reset_hold_value1", rf.value1, 32'h0);
        idle();
        reset = 1'b0;
        rd(5, 5);
        chk("post_reset_r5", rf.value1, 32'h0);

        // Basic two-port read.
        wr(3, 32'h0000FFFF);
        wr(4, 32'h12345678);
        rd(3, 4);
        chk("basic_value1", rf.value1, 32'h0000FFFF);
        chk("basic_value2", rf.value2, 32'h12345678);
        chk("basic_valid",  {31'b0, rf.operands_valid}, 32'h1);

        // $zero: write and read index 0 in the same cycle, then again.
        idle();
        rf.write_en   = 1'b1;
        rf.write_reg  = 5'd0;
        rf.write_data = 32'hFFFFFFFF;
        rf.read_en    = 1'b1;
        tick();
        chk("zero_same_cycle1", rf.value1, 32'h0);
        chk("zero_same_cycle2", rf.value2, 32'h0);
        rd(0, 0);
        chk("zero_value1", rf.value1, 32'h0);
        chk("zero_value2", rf.value2, 32'h0);

        // Collision on r7; port 2 reads an unrelated register.
        wr(7, 32'h11111111);
        idle();
        rf.write_en   = 1'b1;
        rf.write_reg  = 5'd7;
        rf.write_data = 32'h22222222;
        rf.read_en    = 1'b1;
        rf.read_reg1  = 5'd7;
        rf.read_reg2  = 5'd3;
        tick();
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("collide_value1", rf.value1, 32'h22222222);
`else
        chk("collide_value1", rf.value1, 32'h11111111);
`endif
        chk("collide_value2", rf.value2, 32'h0000FFFF);
        rd(7, 7);
        chk("collide_next1", rf.value1, 32'h22222222);
        chk("collide_next2", rf.value2, 32'h22222222);

        // Valid for exactly one cycle, values held afterwards.
        rd(3, 4);
        chk("pulse_valid", {31'b0, rf.operands_valid}, 32'h1);
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_valid",  {31'b0, rf.operands_valid}, 32'h0);
            chk("hold_value1", rf.value1, 32'h0000FFFF);
            chk("hold_value2", rf.value2, 32'h12345678);
        end

        // Sweep: fill r1..r31, then read (i, 31-i) every cycle.
        for (int i = 1; i < 32; i++) wr(i, sweep_val(i));
        for (int i = 0; i < 32; i++) begin
            rd(i, 31 - i);
            chk("sweep_value1", rf.value1, sweep_val(i));
            chk("sweep_value2", rf.value2, sweep_val(31 - i));
            chk("sweep_valid",  {31'b0, rf.operands_valid}, 32'h1);
        end
        idle();
        tick();
        chk("sweep_end_valid", {31'b0, rf.operands_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
